controller_fsm_mc: RTL and testbench
====================================

Name: controller_fsm_mc

Overview:
- Multi-cycle successor to the single-cycle opcode decoder in the CPU datapath.
- Sequences FETCH → DECODE → EXEC per instruction; waits on instruction-memory ready; stretches ALU ops over a parametrised latency; conditionally jumps on Z/C; latches HALT.
- Drives the IR, PC, register-file and accumulator load/select strobes.

Parameters:
- OPCODE_W, 4, opcode width.
- ALU_SEL_W, 4, SelALU width; must be ≥ OPCODE_W; opcode is zero-extended onto it.
- ALU_LAT, 1, cycles an ALU op spends in EXEC; must be ≥ 1.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Rst  in  1  reset, synchronous, active-high.
- Opcode  in  OPCODE_W  opcode field from the instruction register.
- IMemReady  in  1  instruction memory has valid data this cycle.
- Z  in  1  accumulator-zero flag.
- C  in  1  carry/negative flag.
- LoadIR  out  1  load the instruction register.
- IncPC  out  1  PC = PC + 1.
- SelPC  out  1  jump-target select: 0 = register value, 1 = immediate.
- LoadPC  out  1  load the jump target into the PC.
- LoadReg  out  1  write the accumulator into the register file.
- LoadAcc  out  1  write the accumulator.
- SelAcc  out  2  accumulator source: 00 hold, 01 register, 10 immediate, 11 ALU.
- SelALU  out  ALU_SEL_W  ALU operation select.
- Halted  out  1  controller is parked in HALTED.
- Trap  out  1  illegal-opcode trap (see Optional Feature).

Behaviour:
- Encodings, OPCODE_W = 4:
  - ADD 0001, SUB 0010, NOR 0011, SHFL 1011, SHFR 1100.
  - REG_TO_ACC 0100, ACC_TO_REG 0101, IMM_TO_ACC 1101.
  - JMPZ_REG 0110, JMPZ_IMM 0111, JMPC_REG 1000, JMPC_IMM 1010.
  - NOP 0000, HALT 1111.
  - Illegal: 1001, 1110.
  - For OPCODE_W > 4: the codes above are zero-extended; all other values are illegal.
- States: FETCH, DECODE, EXEC, HALTED, TRAP.
- Outputs are combinational from state and OpReg only; never from the live Opcode input outside DECODE.
- Reset:
  - Rst = 1 at an edge forces state FETCH, ALU counter 0, OpReg 0.
  - All outputs are 0 while in reset and for the cycle following it.
  - Reset wins over every other event, including reset in EXEC mid-stretch.
- FETCH:
  - LoadIR = IMemReady.
  - IMemReady = 1 → DECODE; else stay in FETCH. There is no timeout.
- DECODE:
  - OpReg <= Opcode; counter <= 0; next state EXEC.
  - All strobes are 0.
- EXEC, by OpReg:
  - ALU ops:
    - SelALU = OpReg and SelAcc = 11 for the whole stretch.
    - Counter increments each cycle.
    - On the cycle the counter reaches ALU_LAT-1: LoadAcc = 1, IncPC = 1, next state FETCH.
    - ALU_LAT = 1 gives a single EXEC cycle.
  - REG_TO_ACC: LoadAcc = 1, SelAcc = 01, IncPC = 1.
  - IMM_TO_ACC: LoadAcc = 1, SelAcc = 10, IncPC = 1.
  - ACC_TO_REG: LoadReg = 1, IncPC = 1.
  - Conditional jumps:
    - Condition is Z for JMPZ_*, C for JMPC_*, sampled in the EXEC cycle.
    - Taken: LoadPC = 1, IncPC = 0, SelPC = 1 for *_IMM and 0 for *_REG.
    - Not taken: IncPC = 1, LoadPC = 0.
  - NOP: IncPC = 1.
  - HALT: no strobes; next state HALTED.
  - Illegal opcode: treated per Optional Feature.
  - Non-ALU ops: EXEC is 1 cycle, next state FETCH.
- HALTED:
  - Halted = 1; all strobes 0.
  - Left only by Rst.
- Invariants:
  - IncPC and LoadPC are never both 1.
  - LoadAcc and LoadReg are never both 1.
  - SelALU = 0 outside ALU EXEC.
- Latency, with IMemReady held at 1:
  - Non-ALU instruction: 3 cycles.
  - ALU instruction: 2 + ALU_LAT cycles.

Optional Feature:
- Macro: CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - An illegal opcode in EXEC → TRAP; no strobes; IncPC = 0.
  - Trap = 1 and Halted = 0 until Rst.
- Undefined:
  - An illegal opcode executes as NOP (IncPC = 1, back to FETCH).
  - Trap is tied to 0 and the TRAP state is not built.

Decomposition:
- Shared package ctrl_pkg:
  - State enum.
  - Opcode localparams.
  - SelAcc encodings: ACC_HOLD, ACC_REG, ACC_IMM, ACC_ALU.
  - Function is_alu_op(opcode).
  - Function is_legal_op(opcode).
- One sub-module: ctrl_alu_stretch.
  - Parametrised by ALU_LAT.
  - Inputs: start, clear. Output: done.
  - Holds the EXEC counter.
- Everything else stays in controller_fsm_mc.

Test Plan:
- Rst 1 for 2 cycles, then IMemReady = 1 with Opcode 0001 and ALU_LAT = 3 → strobes as follows:
  - LoadIR at cycle 1.
  - SelALU = 0001 and SelAcc = 11 for 3 cycles.
  - LoadAcc and IncPC only on the third EXEC cycle.
  - Next FETCH at cycle 6.
- IMemReady held at 0 for 5 cycles in FETCH → no LoadIR and no state change; LoadIR = 1 on the first cycle IMemReady = 1.
- Opcode 0111:
  - Z = 1 → LoadPC = 1, SelPC = 1, IncPC = 0.
  - Z = 0 → IncPC = 1, LoadPC = 0.
- Opcode 1000:
  - C = 1 → LoadPC = 1, SelPC = 0.
  - C = 0 → IncPC = 1.
- Opcode 1111 → Halted = 1 and no strobes for 10 cycles; Rst → Halted = 0 and FETCH; Rst asserted mid-ALU stretch → all outputs 0 on the next cycle.
- Opcode 1001:
  - With CTRL_ILLEGAL_TRAP_EN → Trap = 1 and held, IncPC = 0.
  - Without → IncPC = 1 and back to FETCH.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared states, opcodes, accumulator selects and opcode classifiers for controller_fsm_mc
package ctrl_pkg;
  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    HALTED
`ifdef CTRL_ILLEGAL_TRAP_EN
    , TRAP
`endif
  } state_t;
  localparam int unsigned OP_NOP        = 4'b0000;
  localparam int unsigned OP_ADD        = 4'b0001;
  localparam int unsigned OP_SUB        = 4'b0010;
  localparam int unsigned OP_NOR        = 4'b0011;
  localparam int unsigned OP_REG_TO_ACC = 4'b0100;
  localparam int unsigned OP_ACC_TO_REG = 4'b0101;
  localparam int unsigned OP_JMPZ_REG   = 4'b0110;
  localparam int unsigned OP_JMPZ_IMM   = 4'b0111;
  localparam int unsigned OP_JMPC_REG   = 4'b1000;
  localparam int unsigned OP_JMPC_IMM   = 4'b1010;
  localparam int unsigned OP_SHFL       = 4'b1011;
  localparam int unsigned OP_SHFR       = 4'b1100;
  localparam int unsigned OP_IMM_TO_ACC = 4'b1101;
  localparam int unsigned OP_HALT       = 4'b1111;
  localparam logic [1:0] ACC_HOLD = 2'b00;
  localparam logic [1:0] ACC_REG  = 2'b01;
  localparam logic [1:0] ACC_IMM  = 2'b10;
  localparam logic [1:0] ACC_ALU  = 2'b11;
  function automatic logic is_alu_op(input int unsigned op);
    return op inside {OP_ADD, OP_SUB, OP_NOR, OP_SHFL, OP_SHFR};
  endfunction
  function automatic logic is_legal_op(input int unsigned op);
    return op < 16 && !(op inside {4'b1001, 4'b1110});
  endfunction
endpackage

// File: rtl/ctrl_alu_stretch.sv
// ctrl_alu_stretch: counts the EXEC cycles of an ALU op and flags the final one
module ctrl_alu_stretch #(
  parameter int ALU_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic clear,
  output logic done
);
  localparam int CW = ALU_LAT > 1 ? $clog2(ALU_LAT) : 1;
  logic [CW-1:0] cnt;
  assign done = cnt == CW'(ALU_LAT - 1);
  always_ff @(posedge clk)
    if (rst || clear) cnt <= '0;
    else if (start && !done) cnt <= cnt + CW'(1);
endmodule

// File: rtl/controller_fsm_mc.sv
// controller_fsm_mc: multi-cycle FETCH/DECODE/EXEC controller; CTRL_ILLEGAL_TRAP_EN builds the illegal-opcode TRAP state
module controller_fsm_mc import ctrl_pkg::*; #(
  parameter int OPCODE_W  = 4,
  parameter int ALU_SEL_W = 4,
  parameter int ALU_LAT   = 1
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [OPCODE_W-1:0]  Opcode,
  input  logic                 IMemReady,
  input  logic                 Z,
  input  logic                 C,
  output logic                 LoadIR,
  output logic                 IncPC,
  output logic                 SelPC,
  output logic                 LoadPC,
  output logic                 LoadReg,
  output logic                 LoadAcc,
  output logic [1:0]           SelAcc,
  output logic [ALU_SEL_W-1:0] SelALU,
  output logic                 Halted,
  output logic                 Trap
);
`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif
  state_t state, state_n;
  logic [OPCODE_W-1:0] op_reg;
  logic rst_q, done, live, ex, alu, legal, jz, jc, taken;
  int unsigned op;
  assign op    = 32'(op_reg);
  assign alu   = is_alu_op(op);
  assign legal = is_legal_op(op);
  assign jz    = op == OP_JMPZ_REG || op == OP_JMPZ_IMM;
  assign jc    = op == OP_JMPC_REG || op == OP_JMPC_IMM;
  assign taken = (jz && Z) || (jc && C);
  // the cycle after reset is a dead cycle: outputs low and FETCH holds
  assign live  = !(Rst || rst_q);
  assign ex    = live && state == EXEC;
  ctrl_alu_stretch #(.ALU_LAT(ALU_LAT)) u_stretch (
    .clk(Clk), .rst(Rst), .start(state == EXEC && alu), .clear(state == DECODE), .done(done)
  );
  always_ff @(posedge Clk) begin
    rst_q <= Rst;
    if (Rst) begin
      state  <= FETCH;
      op_reg <= '0;
    end else begin
      state  <= state_n;
      op_reg <= state == DECODE ? Opcode : op_reg;
    end
  end
  always_comb begin
    state_n = state;
    case (state)
      FETCH:  state_n = IMemReady && !rst_q ? DECODE : FETCH;
      DECODE: state_n = EXEC;
`ifdef CTRL_ILLEGAL_TRAP_EN
      EXEC:   state_n = alu ? (done ? FETCH : EXEC) : op == OP_HALT ? HALTED : !legal ? TRAP : FETCH;
`else
      EXEC:   state_n = alu ? (done ? FETCH : EXEC) : op == OP_HALT ? HALTED : FETCH;
`endif
      default: state_n = state;
    endcase
  end
  always_comb begin
    LoadIR  = live && state == FETCH && IMemReady;
    IncPC   = ex && (alu ? done : (jz || jc) ? !taken : op != OP_HALT && (legal || !TRAP_EN));
    LoadPC  = ex && taken;
    SelPC   = ex && taken && (op == OP_JMPZ_IMM || op == OP_JMPC_IMM);
    LoadReg = ex && op == OP_ACC_TO_REG;
    LoadAcc = ex && (alu ? done : op == OP_REG_TO_ACC || op == OP_IMM_TO_ACC);
    SelAcc  = !ex ? ACC_HOLD : alu ? ACC_ALU : op == OP_REG_TO_ACC ? ACC_REG :
              op == OP_IMM_TO_ACC ? ACC_IMM : ACC_HOLD;
    SelALU  = ex && alu ? ALU_SEL_W'(op_reg) : '0;
    Halted  = live && state == HALTED;
`ifdef CTRL_ILLEGAL_TRAP_EN
    Trap    = live && state == TRAP;
`else
    Trap    = 1'b0;
`endif
  end
endmodule

// File: tb/tb_controller_fsm_mc.sv
// tb_controller_fsm_mc: vector table, hand sequences and randomized instruction stream against a per-instruction model
module tb_controller_fsm_mc;
  localparam int LAT = 3;
`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  logic clk = 1'b0, Rst = 1'b1, IMemReady = 1'b0, Z = 1'b0, C = 1'b0;
  logic [3:0] Opcode = '0;
  logic LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc, Halted, Trap;
  logic [1:0] SelAcc;
  logic [3:0] SelALU;
  logic [13:0] outs;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  controller_fsm_mc #(.OPCODE_W(4), .ALU_SEL_W(4), .ALU_LAT(LAT)) dut (
    .Clk(clk), .Rst(Rst), .Opcode(Opcode), .IMemReady(IMemReady), .Z(Z), .C(C),
    .LoadIR(LoadIR), .IncPC(IncPC), .SelPC(SelPC), .LoadPC(LoadPC), .LoadReg(LoadReg),
    .LoadAcc(LoadAcc), .SelAcc(SelAcc), .SelALU(SelALU), .Halted(Halted), .Trap(Trap)
  );
  assign outs = {LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc, SelAcc, SelALU, Halted, Trap};
  function automatic logic [13:0] ev(input logic ir, inc, spc, lpc, lreg, lacc,
                                     input logic [1:0] sa, input logic [3:0] alu, input logic h, t);
    return {ir, inc, spc, lpc, lreg, lacc, sa, alu, h, t};
  endfunction
  localparam logic [13:0] ZERO = 14'd0;
  localparam logic [13:0] FET  = 14'b10_0000_00_0000_00;
  localparam logic [13:0] HLT  = 14'b00_0000_00_0000_10;
  localparam logic [13:0] TRP  = 14'b00_0000_00_0000_01;
  localparam logic [13:0] INC  = 14'b01_0000_00_0000_00;
  // expected strobes for exec cycle k of an instruction, straight from the opcode table
  function automatic logic [13:0] model(input logic [3:0] op, input logic z, c, input int k, output logic last);
    last = 1'b1;
    case (op)
      4'd1, 4'd2, 4'd3, 4'd11, 4'd12: begin
        last = k == LAT - 1;
        return ev(0, last, 0, 0, 0, last, 2'b11, op, 0, 0);
      end
      4'd4:  return ev(0, 1, 0, 0, 0, 1, 2'b01, 0, 0, 0);
      4'd13: return ev(0, 1, 0, 0, 0, 1, 2'b10, 0, 0, 0);
      4'd5:  return ev(0, 1, 0, 0, 1, 0, 2'b00, 0, 0, 0);
      4'd6:  return z ? ev(0, 0, 0, 1, 0, 0, 0, 0, 0, 0) : INC;
      4'd7:  return z ? ev(0, 0, 1, 1, 0, 0, 0, 0, 0, 0) : INC;
      4'd8:  return c ? ev(0, 0, 0, 1, 0, 0, 0, 0, 0, 0) : INC;
      4'd10: return c ? ev(0, 0, 1, 1, 0, 0, 0, 0, 0, 0) : INC;
      4'd15: return ZERO;
      4'd9, 4'd14: return TRAP ? ZERO : INC;
      default: return INC;
    endcase
  endfunction
  task automatic cyc(input logic r, rdy, input logic [3:0] op, input logic z, c,
                     input logic [13:0] exp, input string nm);
    Rst = r; IMemReady = rdy; Opcode = op; Z = z; C = c;
    #4;
    checks++;
    if (outs !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (IR IPC SPC LPC LREG LACC SA[2] ALU[4] H T)", nm, outs, exp);
    end
    @(posedge clk); #1;
  endtask
  task automatic instr(input logic [3:0] op, input int waits);
    logic last, z, c;
    int k;
    repeat (waits) cyc(0, 0, 4'($urandom), 1'($urandom), 1'($urandom), ZERO, "fetch_wait");
    cyc(0, 1, 4'($urandom), 1'($urandom), 1'($urandom), FET, "fetch");
    cyc(0, 1'($urandom), op, 1'($urandom), 1'($urandom), ZERO, "decode");
    k = 0;
    do begin
      z = 1'($urandom); c = 1'($urandom);
      cyc(0, 1'($urandom), 4'($urandom), z, c, model(op, z, c, k, last), $sformatf("exec_op%0d_k%0d", op, k));
      k++;
    end while (!last && k < 16);
  endtask
  typedef struct {
    logic [3:0] op;
    logic z, c;
    logic [13:0] exp;
    string nm;
  } vec_t;
  vec_t tbl[12];
  initial begin
    logic [3:0] rop;
    tbl[0]  = '{4'b0111, 1, 0, ev(0, 0, 1, 1, 0, 0, 0, 0, 0, 0), "jmpz_imm_taken"};
    tbl[1]  = '{4'b0111, 0, 1, INC,                             "jmpz_imm_not"};
    tbl[2]  = '{4'b1000, 0, 1, ev(0, 0, 0, 1, 0, 0, 0, 0, 0, 0), "jmpc_reg_taken"};
    tbl[3]  = '{4'b1000, 1, 0, INC,                             "jmpc_reg_not"};
    tbl[4]  = '{4'b0110, 1, 1, ev(0, 0, 0, 1, 0, 0, 0, 0, 0, 0), "jmpz_reg_taken"};
    tbl[5]  = '{4'b1010, 0, 1, ev(0, 0, 1, 1, 0, 0, 0, 0, 0, 0), "jmpc_imm_taken"};
    tbl[6]  = '{4'b0100, 0, 0, ev(0, 1, 0, 0, 0, 1, 2'b01, 0, 0, 0), "reg_to_acc"};
    tbl[7]  = '{4'b1101, 1, 1, ev(0, 1, 0, 0, 0, 1, 2'b10, 0, 0, 0), "imm_to_acc"};
    tbl[8]  = '{4'b0101, 0, 0, ev(0, 1, 0, 0, 1, 0, 2'b00, 0, 0, 0), "acc_to_reg"};
    tbl[9]  = '{4'b0000, 1, 1, INC,                             "nop"};
    tbl[10] = '{4'b1010, 1, 0, INC,                             "jmpc_imm_not"};
    tbl[11] = '{4'b0110, 0, 1, INC,                             "jmpz_reg_not"};
    @(posedge clk); #1;
    cyc(1, 1, 4'hF, 1, 1, ZERO, "reset_0");
    cyc(1, 1, 4'hF, 1, 1, ZERO, "reset_1");
    cyc(0, 1, 4'h1, 0, 0, ZERO, "post_reset");
    cyc(0, 1, 4'h1, 0, 0, FET, "add_fetch_c1");
    cyc(0, 1, 4'h1, 0, 0, ZERO, "add_decode");
    cyc(0, 1, 4'h0, 0, 0, ev(0, 0, 0, 0, 0, 0, 2'b11, 4'h1, 0, 0), "add_exec0");
    cyc(0, 1, 4'h0, 0, 0, ev(0, 0, 0, 0, 0, 0, 2'b11, 4'h1, 0, 0), "add_exec1");
    cyc(0, 1, 4'h0, 0, 0, ev(0, 1, 0, 0, 0, 1, 2'b11, 4'h1, 0, 0), "add_exec2");
    cyc(0, 1, 4'h0, 0, 0, FET, "add_next_fetch_c6");
    cyc(0, 1, 4'h0, 0, 0, ZERO, "nop_decode");
    cyc(0, 1, 4'h0, 0, 0, INC, "nop_exec");
    repeat (5) cyc(0, 0, 4'h3, 1, 1, ZERO, "imem_wait");
    cyc(0, 1, 4'h3, 0, 0, FET, "imem_ready_fetch");
    cyc(0, 1, 4'h0, 0, 0, ZERO, "nop2_decode");
    cyc(0, 1, 4'h0, 0, 0, INC, "nop2_exec");
    for (int i = 0; i < 12; i++) begin
      cyc(0, 1, 4'($urandom), 0, 0, FET, {tbl[i].nm, "_fetch"});
      cyc(0, 1, tbl[i].op, 0, 0, ZERO, {tbl[i].nm, "_decode"});
      cyc(0, 1, 4'($urandom), tbl[i].z, tbl[i].c, tbl[i].exp, tbl[i].nm);
    end
    for (int n = 0; n < 60; n++) begin
      do rop = 4'($urandom); while (rop == 4'hF || (TRAP && (rop == 4'h9 || rop == 4'hE)));
      instr(rop, $urandom_range(0, 3));
    end
    cyc(0, 1, 4'h0, 0, 0, FET, "mid_fetch");
    cyc(0, 1, 4'h2, 0, 0, ZERO, "mid_decode");
    cyc(0, 1, 4'h0, 0, 0, ev(0, 0, 0, 0, 0, 0, 2'b11, 4'h2, 0, 0), "mid_exec0");
    cyc(1, 1, 4'h0, 0, 0, ZERO, "mid_reset");
    cyc(0, 1, 4'h0, 0, 0, ZERO, "mid_post_reset");
    cyc(0, 1, 4'h0, 0, 0, FET, "mid_refetch");
    cyc(0, 1, 4'hF, 0, 0, ZERO, "halt_decode");
    cyc(0, 1, 4'h0, 1, 1, ZERO, "halt_exec");
    for (int i = 0; i < 10; i++) cyc(0, 1, 4'($urandom), 1'($urandom), 1'($urandom), HLT, $sformatf("halted_%0d", i));
    cyc(1, 1, 4'h0, 0, 0, ZERO, "halt_reset");
    cyc(0, 1, 4'h0, 0, 0, ZERO, "halt_post_reset");
    cyc(0, 1, 4'h0, 0, 0, FET, "halt_refetch");
    cyc(0, 1, 4'h9, 0, 0, ZERO, "ill_decode");
    cyc(0, 1, 4'h0, 0, 0, TRAP ? ZERO : INC, "ill_exec");
    if (TRAP) for (int i = 0; i < 4; i++) cyc(0, 1, 4'($urandom), 1, 1, TRP, $sformatf("trap_hold_%0d", i));
    else cyc(0, 1, 4'h0, 0, 0, FET, "ill_refetch");
    cyc(1, 1, 4'h0, 0, 0, ZERO, "final_reset");
    cyc(0, 1, 4'h0, 0, 0, ZERO, "final_post_reset");
    cyc(0, 1, 4'h0, 0, 0, FET, "final_fetch");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
